// File: rtl/port_uart_tx_if.sv
// port_uart_tx_if: processor-side bus of the serial output port.
//   wr_en        - one-cycle byte store strobe (port address already decoded)
//   wr_data      - byte to queue for transmission
//   clr_overflow - clears the sticky overflow flag
//   busy         - a frame is on the line
//   fifo_empty   - no bytes queued
//   fifo_full    - 2**FIFO_AW bytes queued
//   fifo_count   - number of queued bytes (not counting the byte being shifted)
//   overflow     - sticky: a store was dropped because the FIFO was full
// master = processor side, slave = peripheral side.
interface port_uart_tx_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               clr_overflow;
    logic               busy;
    logic               fifo_empty;
    logic               fifo_full;
    logic [FIFO_AW:0]   fifo_count;
    logic               overflow;

    modport master (
        output wr_en, wr_data, clr_overflow,
        input  busy, fifo_empty, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_overflow,
        output busy, fifo_empty, fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/port_uart_tx.sv
// port_uart_tx: memory-mapped UART transmitter behind the processor output port.
// Byte stores are queued in a circular FIFO and sent as 8N1 frames, LSB first.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - processor-side store/status bus (slave modport)
//   tx    - UART serial line, idle high, driven from a register
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    port_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0]   BaudLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CountFull = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               empty_q, full_q;
    logic               overflow_q, overflow_d;

    logic               push, pop, bit_end;

    // The full decision uses registered state, so a same-cycle pop never makes room.
    assign push    = bus.wr_en & ~full_q;
    assign bit_end = (baud_q == BaudLast);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // FSM next state; pops happen only when a frame is started
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        // back-to-back frame, no idle gap
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, computed from the next state so tx/busy come straight off flops
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping and sticky overflow (set wins over clear)
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (bus.wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CountFull);
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign tx             = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: bench for port_uart_tx. A queue-based reference model tracks
// the queued bytes and the position inside the current frame; the expected line
// level is derived from that position (bit slot = pos / CLKS_PER_BIT).
module tb_port_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset;
    logic tx;

    port_uart_tx_if #(.FIFO_AW(AW)) bus ();

    port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    byte unsigned mq[$];
    bit           m_active = 1'b0;
    int           m_pos    = 0;
    byte unsigned m_cur    = 8'h00;
    bit           m_ovf    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input bit we, input byte unsigned d, input bit clr, input bit rst);
        int size_pre;
        bit full_pre;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
            return;
        end
        size_pre = mq.size();
        full_pre = (size_pre == DEPTH);
        if (!m_active) begin
            if (size_pre > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos = 0;
                if (size_pre > 0) m_cur = mq.pop_front();
                else m_active = 1'b0;
            end
        end
        if (we && !full_pre) mq.push_back(d);
        if (we && full_pre) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare 1 ns later.
    task automatic step(input bit we, input byte unsigned d, input bit clr, input bit rst);
        bus.wr_en        = we;
        bus.wr_data      = d;
        bus.clr_overflow = clr;
        reset            = rst;
        @(posedge clk);
        model_edge(we, d, clr, rst);
        #1;
        check("tx",         32'(tx),             32'(exp_tx()));
        check("busy",       32'(bus.busy),       32'(m_active));
        check("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
        check("fifo_empty", 32'(bus.fifo_empty), 32'(mq.size() == 0));
        check("fifo_full",  32'(bus.fifo_full),  32'(mq.size() == DEPTH));
        check("overflow",   32'(bus.overflow),   32'(m_ovf));
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.clr_overflow = 1'b0;
        reset            = 1'b1;

        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        run_idle(3);

        // single byte
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        run_idle(50);

        // back-to-back frames
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        run_idle(90);

        // fill past capacity: 0x0A is dropped
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        run_idle(9 * FRAME + 20);

        // overflow set wins over same-cycle clear
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // write while full exactly on the STOP->START pop edge
        for (int i = 0; i < 200 && !(m_active && m_pos == FRAME - 1); i++) run_idle(1);
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        run_idle(9 * FRAME + 20);

        // reset 13 cycles into a frame with 3 bytes queued
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 50 && m_pos != 12; i++) run_idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        run_idle(100);

        // randomized traffic, alternating heavy and light write rates
        for (int i = 0; i < 4000; i++) begin
            int rate;
            bit we, clr, rst;
            rate = ((i / 500) % 2 == 0) ? 50 : 3;
            we   = ($urandom_range(0, 99) < rate);
            clr  = ($urandom_range(0, 49) == 0);
            rst  = ($urandom_range(0, 799) == 0);
            step(we, 8'($urandom), clr, rst);
        end
        run_idle(DEPTH * FRAME + 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
